// File: rtl/wav_sel_ctrl.sv
// Waveform select sequencer: debounced next/auto buttons, auto-step timer and
// a midscale-crossing deferred switch of the oscillator mux select.
module wav_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 48000,
  parameter int ZC_TIMEOUT      = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_auto,
  input  logic       sample_tick,
  input  logic [7:0] cur_sample,
  output logic [1:0] sel,
  output logic       pending,
  output logic       auto_on
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW  = $clog2(AUTO_PERIOD + 1);
  localparam int TW  = $clog2(ZC_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0]  AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [TW-1:0]  ZC_LAST   = TW'(ZC_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ZC, SETTLE} state_e;

  // Bit 0 is the next button, bit 1 the auto button.
  logic [1:0]     sync1_q, sync2_q, deb_q, press;
  logic [DBW-1:0] db_cnt_q [2];

  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          auto_on_q, auto_on_d;
  logic          prev_msb_q, prev_msb_d;
  state_e        state_q, state_d;
  logic [1:0]    tgt_q, tgt_d, sel_q, sel_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          defer_q, defer_d, pending_q, pending_d;

  logic next_press, auto_press, auto_step, req, crossing;

  // Synchronise and debounce: a new level is accepted only after it has
  // disagreed with the accepted level for DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q <= {btn_auto, btn_next};
      sync2_q <= sync1_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (db_cnt_q[b] == DB_LAST) begin
            deb_q[b]    <= sync2_q[b];
            db_cnt_q[b] <= '0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
          end
        end else begin
          db_cnt_q[b] <= '0;
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int b = 0; b < 2; b++)
      press[b] = (sync2_q[b] != deb_q[b]) && (db_cnt_q[b] == DB_LAST) && sync2_q[b];
  end

  assign next_press = press[0];
  assign auto_press = press[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt_q <= '0;
      auto_on_q  <= 1'b0;
      prev_msb_q <= 1'b0;
      state_q    <= IDLE;
      tgt_q      <= '0;
      sel_q      <= '0;
      to_cnt_q   <= '0;
      defer_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
      auto_on_q  <= auto_on_d;
      prev_msb_q <= prev_msb_d;
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      sel_q      <= sel_d;
      to_cnt_q   <= to_cnt_d;
      defer_q    <= defer_d;
      pending_q  <= pending_d;
    end
  end

  // A next press and an auto step landing together form a single request.
  always_comb begin
    auto_step  = auto_on_q && sample_tick && (auto_cnt_q == AUTO_LAST);
    auto_on_d  = auto_on_q ^ auto_press;
    auto_cnt_d = auto_cnt_q;
    if (next_press || auto_press)
      auto_cnt_d = '0;
    else if (auto_on_q && sample_tick)
      auto_cnt_d = auto_step ? '0 : auto_cnt_q + 1'b1;
    req        = next_press || auto_step;
    crossing   = sample_tick && (cur_sample[7] != prev_msb_q);
    prev_msb_d = sample_tick ? cur_sample[7] : prev_msb_q;
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    sel_d     = sel_q;
    to_cnt_d  = to_cnt_q;
    defer_d   = defer_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          tgt_d     = sel_q + 2'd1;
          to_cnt_d  = '0;
          pending_d = 1'b1;
          state_d   = WAIT_ZC;
        end
      end
      WAIT_ZC: begin
        if (crossing || (sample_tick && to_cnt_q == ZC_LAST)) begin
          sel_d     = tgt_q;
          pending_d = 1'b0;
          defer_d   = req;
          state_d   = SETTLE;
        end else begin
          if (req) tgt_d = tgt_q + 2'd1;
          if (sample_tick) to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        // Hold off one sample so the mux output reflects the new waveform.
        if (sample_tick) begin
          defer_d = 1'b0;
          if (defer_q || req) begin
            tgt_d     = sel_q + 2'd1;
            to_cnt_d  = '0;
            pending_d = 1'b1;
            state_d   = WAIT_ZC;
          end else begin
            state_d = IDLE;
          end
        end else if (req) begin
          defer_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel     = sel_q;
    pending = pending_q;
    auto_on = auto_on_q;
  end

endmodule

// File: tb/tb_wav_sel_ctrl.sv
// Bench for wav_sel_ctrl: directed scenarios plus random stimulus, checked every
// cycle against a step-counting behavioural model.
module tb_wav_sel_ctrl;

  localparam int DEB = 8;
  localparam int PER = 5;
  localparam int ZCT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnNext = 1'b0;
  logic       btnAuto = 1'b0;
  logic       sampleTick = 1'b0;
  logic [7:0] curSample = 8'h00;
  logic [1:0] sel;
  logic       pending;
  logic       autoOn;

  int totalChecks = 0;
  int badChecks = 0;
  bit checkEn = 1'b0;
  bit lastMsb = 1'b0;

  wav_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(PER), .ZC_TIMEOUT(ZCT)) dut (
    .clk(clk), .rst(rst), .btn_next(btnNext), .btn_auto(btnAuto),
    .sample_tick(sampleTick), .cur_sample(curSample),
    .sel(sel), .pending(pending), .auto_on(autoOn)
  );

  always #5 clk = ~clk;

  // Model: buttons as delayed levels with a disagreement run length, the
  // switch as a count of outstanding steps added to sel when it fires.
  bit mSh1[2], mSh2[2], mAcc[2], mPr[2], mRaw[2];
  int mRun[2];
  int mAcnt, mSteps, mWaited, mSel;
  bit mAuto, mPrev, mDefer, mWaiting, mSettling, mStep, mReq, mCross, mFire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        mSh1[b] = 0; mSh2[b] = 0; mAcc[b] = 0; mRun[b] = 0;
      end
      mAcnt = 0; mSteps = 0; mWaited = 0; mSel = 0;
      mAuto = 0; mPrev = 0; mDefer = 0; mWaiting = 0; mSettling = 0;
    end else begin
      mRaw[0] = btnNext;
      mRaw[1] = btnAuto;
      for (int b = 0; b < 2; b++) begin
        mPr[b] = 0;
        if (mSh2[b] != mAcc[b]) begin
          mRun[b]++;
          if (mRun[b] == DEB) begin
            mAcc[b] = mSh2[b];
            mPr[b] = mSh2[b];
            mRun[b] = 0;
          end
        end else mRun[b] = 0;
        mSh2[b] = mSh1[b];
        mSh1[b] = mRaw[b];
      end
      mStep = mAuto && sampleTick && (mAcnt == PER - 1);
      if (mPr[0] || mPr[1]) mAcnt = 0;
      else if (mAuto && sampleTick) mAcnt = mStep ? 0 : mAcnt + 1;
      if (mPr[1]) mAuto = !mAuto;
      mReq = mPr[0] || mStep;
      mCross = sampleTick && (curSample[7] != mPrev);
      if (sampleTick) mPrev = curSample[7];
      if (mWaiting) begin
        mFire = mCross || (sampleTick && mWaited == ZCT - 1);
        if (mFire) begin
          mSel = (mSel + mSteps) % 4;
          mSteps = 0;
          mDefer = mReq;
          mWaiting = 0;
          mSettling = 1;
        end else begin
          if (mReq) mSteps++;
          if (sampleTick) mWaited++;
        end
      end else if (mSettling) begin
        if (sampleTick) begin
          mSettling = 0;
          if (mDefer || mReq) begin
            mWaiting = 1; mSteps = 1; mWaited = 0;
          end
          mDefer = 0;
        end else if (mReq) mDefer = 1;
      end else if (mReq) begin
        mWaiting = 1; mSteps = 1; mWaited = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("sel", 8'(sel), 8'(mSel));
      checkOutput("pending", 8'(pending), 8'(mWaiting));
      checkOutput("auto_on", 8'(autoOn), 8'(mAuto));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit nxt, input bit aut, input bit tick, input logic [7:0] smp, input int n);
    btnNext = nxt;
    btnAuto = aut;
    sampleTick = tick;
    curSample = smp;
    if (tick) lastMsb = smp[7];
    cycles(1);
    sampleTick = 1'b0;
    if (n > 1) cycles(n - 1);
  endtask

  task automatic pressNext();
    applyStimulus(1, 0, 0, curSample, 14);
    applyStimulus(0, 0, 0, curSample, 14);
  endtask

  task automatic pressAuto();
    applyStimulus(0, 1, 0, curSample, 14);
    applyStimulus(0, 0, 0, curSample, 14);
  endtask

  task automatic tickVal(input logic [7:0] v);
    applyStimulus(0, 0, 1, v, 2);
  endtask

  task automatic crossTick();
    tickVal(lastMsb ? 8'h10 : 8'h90);
  endtask

  task automatic sameTick();
    tickVal(lastMsb ? 8'h90 : 8'h10);
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_sel", 8'(sel), 8'd0);
    checkOutput("reset_pending", 8'(pending), 8'd0);
    checkOutput("reset_auto", 8'(autoOn), 8'd0);

    // Held press, then a midscale crossing on the third sample.
    applyStimulus(1, 0, 0, 8'h00, 20);
    applyStimulus(0, 0, 0, 8'h00, 14);
    checkOutput("t1_pending", 8'(pending), 8'd1);
    tickVal(8'h10);
    tickVal(8'h40);
    checkOutput("t1_sel_before", 8'(sel), 8'd0);
    applyStimulus(0, 0, 1, 8'h90, 1);
    checkOutput("t1_sel_after", 8'(sel), 8'd1);
    checkOutput("t1_pending_after", 8'(pending), 8'd0);
    cycles(1);
    sameTick();

    // Short bounce is ignored.
    applyStimulus(1, 0, 0, curSample, 3);
    applyStimulus(0, 0, 0, curSample, 20);
    checkOutput("t2_sel", 8'(sel), 8'd1);
    checkOutput("t2_pending", 8'(pending), 8'd0);

    pressNext();
    crossTick();
    sameTick();
    checkOutput("t3_start_sel", 8'(sel), 8'd2);

    // Four requests queued in one wait wrap back to the same waveform.
    repeat (4) pressNext();
    checkOutput("t3_pending", 8'(pending), 8'd1);
    crossTick();
    checkOutput("t3_sel", 8'(sel), 8'd2);
    checkOutput("t3_pending_after", 8'(pending), 8'd0);
    sameTick();

    // No crossing: the switch is forced on the ZCT-th sample.
    tickVal(8'h20);
    pressNext();
    repeat (3) tickVal(8'h20);
    checkOutput("t4_sel_wait", 8'(sel), 8'd2);
    checkOutput("t4_pending_wait", 8'(pending), 8'd1);
    tickVal(8'h20);
    checkOutput("t4_sel_forced", 8'(sel), 8'd3);
    tickVal(8'h20);

    // Auto stepping.
    pressAuto();
    checkOutput("t5_auto_on", 8'(autoOn), 8'd1);
    for (int i = 1; i <= 26; i++) begin
      tickVal((i % 2) ? 8'hFF : 8'h00);
      if (i == 11) checkOutput("t5_sel_tick11", 8'(sel), 8'd1);
    end
    checkOutput("t5_sel_tick26", 8'(sel), 8'd0);
    tickVal(8'hFF);
    pressAuto();
    checkOutput("t5_auto_off", 8'(autoOn), 8'd0);
    for (int i = 0; i < 12; i++) tickVal((i % 2) ? 8'hFF : 8'h00);
    checkOutput("t5_sel_stopped", 8'(sel), 8'd0);
    checkOutput("t5_pending_stopped", 8'(pending), 8'd0);

    // Reset while waiting with target 3.
    pressNext();
    crossTick();
    sameTick();
    pressNext();
    pressNext();
    checkOutput("t6_pending_before", 8'(pending), 8'd1);
    checkOutput("t6_sel_before", 8'(sel), 8'd1);
    #2;
    rst = 1'b1;
    lastMsb = 1'b0;
    #1;
    checkOutput("t6_sel_async", 8'(sel), 8'd0);
    checkOutput("t6_pending_async", 8'(pending), 8'd0);
    checkOutput("t6_auto_async", 8'(autoOn), 8'd0);
    cycles(3);
    rst = 1'b0;
    repeat (4) crossTick();
    checkOutput("t6_sel_after", 8'(sel), 8'd0);
    checkOutput("t6_pending_after", 8'(pending), 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) btnNext = ~btnNext;
      if ($urandom_range(0, 96) == 0) btnAuto = ~btnAuto;
      sampleTick = ($urandom_range(0, 3) == 0);
      curSample = 8'($urandom_range(0, 255));
      cycles(1);
    end
    sampleTick = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
